// File: rtl/da_bit_modulator_pkg.sv
// Shared definitions for the DA bit modulator: FSM state encoding and
// default DA codes / frame length.
package da_bit_modulator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_STALL    = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  localparam logic [9:0] DEF_IDLE_CODE = 10'h200;
  localparam logic [9:0] DEF_HIGH_CODE = 10'h3FF;
  localparam logic [9:0] DEF_LOW_CODE  = 10'h000;

  // 784-bit MNIST image packed into bytes
  localparam int MNIST_FRAME_LEN = 98;

endpackage

// File: rtl/da_bit_modulator_bit_timer.sv
// SPB-cycle bit timer. Free-runs while run_i is high, wrapping to zero at
// the end of each bit so back-to-back bits need no gap cycle.
module da_bit_modulator_bit_timer #(
  parameter int SPB = 50
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic restart_i,
  output logic bit_end_o
);

  localparam int TW = $clog2(SPB);
  localparam logic [TW-1:0] LAST = TW'(SPB - 1);

  logic [TW-1:0] cnt_q;

  assign bit_end_o = run_i & (cnt_q == LAST);

  // Count cycles within a bit; restart forces alignment to a fresh bit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          cnt_q <= '0;
    else if (restart_i) cnt_q <= '0;
    else if (run_i)     cnt_q <= bit_end_o ? '0 : cnt_q + 1'b1;
  end

endmodule

// File: rtl/da_bit_modulator.sv
// Frame serialiser for the DA output path: alternating preamble followed by
// payload bytes MSB-first, one NRZ bit per SPB clocks, fed through a
// one-entry hold register over a valid/ready handshake.
module da_bit_modulator
  import da_bit_modulator_pkg::*;
#(
  parameter int              DA_W          = 10,
  parameter int              SPB           = 50,
  parameter int              PREAMBLE_BITS = 8,
  parameter int              FRAME_LEN     = MNIST_FRAME_LEN,
  parameter logic [DA_W-1:0] IDLE_CODE     = DA_W'(DEF_IDLE_CODE),
  parameter logic [DA_W-1:0] HIGH_CODE     = DA_W'(DEF_HIGH_CODE),
  parameter logic [DA_W-1:0] LOW_CODE      = DA_W'(DEF_LOW_CODE)
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            start,
  input  logic [7:0]      byte_data,
  input  logic            byte_valid,
  output logic            byte_ready,
  output logic [DA_W-1:0] da_data,
  output logic            busy,
  output logic            frame_done,
  output logic            underrun
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam int PW = (PREAMBLE_BITS > 1) ? $clog2(PREAMBLE_BITS) : 1;
  localparam logic [CW-1:0] FRAME_LEN_C = CW'(FRAME_LEN);
  localparam logic [PW-1:0] PRE_LAST    = PW'(PREAMBLE_BITS - 1);

  state_e          state_q, state_d;
  logic [DA_W-1:0] da_q, da_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [2:0]      bidx_q, bidx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic [CW-1:0]   acc_q, acc_d;   // bytes accepted into the hold register
  logic [CW-1:0]   shf_q, shf_d;   // bytes loaded into the shifter
  logic            unr_q, unr_d;
  logic            load, tmr_restart, tmr_run, bit_end, accept;

  function automatic logic [DA_W-1:0] bit_code(input logic b);
    return b ? HIGH_CODE : LOW_CODE;
  endfunction

  assign busy       = (state_q == ST_PREAMBLE) | (state_q == ST_SHIFT) |
                      (state_q == ST_STALL);
  assign byte_ready = busy & ~hold_full_q & (acc_q < FRAME_LEN_C);
  assign accept     = byte_valid & byte_ready;
  assign tmr_run    = (state_q == ST_PREAMBLE) | (state_q == ST_SHIFT);
  assign frame_done = (state_q == ST_DONE);
  assign da_data    = da_q;
  assign underrun   = unr_q;

  da_bit_modulator_bit_timer #(.SPB(SPB)) u_timer (
    .clk_i     (sys_clk),
    .rst_i     (sys_rst),
    .run_i     (tmr_run),
    .restart_i (tmr_restart),
    .bit_end_o (bit_end)
  );

  // Next-state, next DA code and hold/shifter bookkeeping
  always_comb begin
    state_d     = state_q;
    da_d        = da_q;
    pre_d       = pre_q;
    bidx_d      = bidx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    acc_d       = acc_q;
    shf_d       = shf_q;
    unr_d       = unr_q;
    load        = 1'b0;
    tmr_restart = 1'b0;

    case (state_q)
      ST_IDLE: begin
        da_d = IDLE_CODE;
        if (start) begin
          state_d     = ST_PREAMBLE;
          da_d        = HIGH_CODE;
          tmr_restart = 1'b1;
          pre_d       = '0;
          acc_d       = '0;
          shf_d       = '0;
          hold_full_d = 1'b0;
          unr_d       = 1'b0;
        end
      end
      ST_PREAMBLE: begin
        if (bit_end) begin
          if (pre_q == PRE_LAST) begin
            if (hold_full_q) begin
              load    = 1'b1;
              state_d = ST_SHIFT;
              da_d    = bit_code(hold_q[7]);
            end else begin
              state_d = ST_STALL;
              da_d    = IDLE_CODE;
              unr_d   = 1'b1;
            end
          end else begin
            pre_d = pre_q + 1'b1;
            // next index is odd when the current one is even
            da_d  = pre_q[0] ? HIGH_CODE : LOW_CODE;
          end
        end
      end
      ST_SHIFT: begin
        if (bit_end) begin
          if (bidx_q == 3'd0) begin
            if (shf_q == FRAME_LEN_C) begin
              state_d = ST_DONE;
              da_d    = IDLE_CODE;
            end else if (hold_full_q) begin
              load = 1'b1;
              da_d = bit_code(hold_q[7]);
            end else begin
              state_d = ST_STALL;
              da_d    = IDLE_CODE;
              unr_d   = 1'b1;
            end
          end else begin
            bidx_d  = bidx_q - 3'd1;
            shift_d = {shift_q[6:0], 1'b0};
            da_d    = bit_code(shift_q[6]);
          end
        end
      end
      ST_STALL: begin
        da_d  = IDLE_CODE;
        unr_d = 1'b1;
        if (hold_full_q) begin
          load        = 1'b1;
          tmr_restart = 1'b1;
          state_d     = ST_SHIFT;
          da_d        = bit_code(hold_q[7]);
        end
      end
      ST_DONE: begin
        da_d    = IDLE_CODE;
        state_d = ST_IDLE;
      end
      default: begin
        da_d    = IDLE_CODE;
        state_d = ST_IDLE;
      end
    endcase

    if (load) begin
      shift_d     = hold_q;
      bidx_d      = 3'd7;
      shf_d       = shf_q + 1'b1;
      hold_full_d = 1'b0;
    end
    // an accept in the same cycle as a load leaves the register full
    if (accept) begin
      hold_d      = byte_data;
      hold_full_d = 1'b1;
      acc_d       = acc_q + 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      da_q        <= IDLE_CODE;
      pre_q       <= '0;
      bidx_q      <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      acc_q       <= '0;
      shf_q       <= '0;
      unr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      da_q        <= da_d;
      pre_q       <= pre_d;
      bidx_q      <= bidx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      acc_q       <= acc_d;
      shf_q       <= shf_d;
      unr_q       <= unr_d;
    end
  end

endmodule
